inst_fetch_buffer: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle datapath: owns the fetch PC, issues sequential addresses to a fixed-latency instruction memory, and queues returned instructions with their PCs in a small FIFO. Decode pulls instructions through a valid/ready handshake. A redirect from the branch logic flushes the queue and any in-flight fetch, then restarts fetching at the new target.

---
 rtl/inst_fetch_buffer.sv | 107 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues sequential fixed-latency fetches and queues {pc, inst} for decode.
// Optional macro INST_FETCH_BYPASS_EN lets a response skip the empty queue straight to the output.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic                     o_imem_req,
    output logic [63:0]              o_imem_addr,
    input  logic [31:0]              i_imem_rdata,
    input  logic                     i_redirect,
    input  logic [63:0]              i_redirect_pc,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [31:0]              o_out_inst,
    output logic [63:0]              o_out_pc,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   r_fetch_pc;
    logic          r_rsp_valid;
    logic [63:0]   r_rsp_pc;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];

    logic [63:0]   w_target;
    logic [CW-1:0] w_occ;
    logic          w_credit;
    logic          w_fifo_nonempty;
    logic          w_push;
    logic          w_pop;

    assign w_target        = i_redirect_pc & ~64'h3;
    // Credit counts the in-flight response but not a same-cycle pop, so the queue can never overflow.
    assign w_occ           = r_count + {{(CW-1){1'b0}}, r_rsp_valid};
    assign w_credit        = w_occ < CW'(DEPTH);
    assign w_fifo_nonempty = (r_count != '0);

    assign o_imem_req  = !i_reset && !i_redirect && w_credit;
    assign o_imem_addr = r_fetch_pc;
    assign o_count     = r_count;

`ifdef INST_FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = !w_fifo_nonempty && r_rsp_valid;
    assign o_out_valid = (w_fifo_nonempty || r_rsp_valid) && !i_redirect;
    assign o_out_inst  = w_bypass ? i_imem_rdata : r_fifo_inst[r_rd_ptr];
    assign o_out_pc    = w_bypass ? r_rsp_pc     : r_fifo_pc[r_rd_ptr];
    assign w_push      = r_rsp_valid && !(w_bypass && i_out_ready);
    assign w_pop       = o_out_valid && i_out_ready && !w_bypass;
`else
    assign o_out_valid = w_fifo_nonempty && !i_redirect;
    assign o_out_inst  = r_fifo_inst[r_rd_ptr];
    assign o_out_pc    = r_fifo_pc[r_rd_ptr];
    assign w_push      = r_rsp_valid;
    assign w_pop       = o_out_valid && i_out_ready;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc  <= RESET_PC;
            r_rsp_valid <= 1'b0;
            r_rsp_pc    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else if (i_redirect) begin
            r_fetch_pc  <= w_target;
            r_rsp_valid <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (o_imem_req) begin
                r_fetch_pc  <= r_fetch_pc + 64'd4;
                r_rsp_valid <= 1'b1;
                r_rsp_pc    <= r_fetch_pc;
            end else begin
                r_rsp_valid <= 1'b0;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_redirect && w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_inst[r_wr_ptr] <= i_imem_rdata;
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset || i_redirect)
                                    w_push |-> (r_count < CW'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer: issued PCs are queued and compared in order against popped entries.
module tb_inst_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef INST_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [$clog2(DEPTH):0] count;

    int          total = 0;
    int          bad   = 0;
    int          n_req = 0;
    int          n_pop = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_pc;

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk(clk), .i_reset(reset), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdata(imem_rdata), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_inst(out_inst),
        .o_out_pc(out_pc), .o_count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor/scoreboard for one cycle (called after inputs settle), then the memory model answers one cycle later.
    task automatic tick();
        logic [63:0] e;
        logic [31:0] next_data;
        next_data = 32'hDEAD_BEEF;
        if (reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL req_in_reset got=%b want=0", imem_req); end
        end else if (redirect) begin
            exp_q.delete();
            model_pc = redirect_pc & ~64'h3;
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL req_in_redirect got=%b want=0", imem_req); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL valid_in_redirect got=%b want=0", out_valid); end
        end else begin
            if (out_valid && out_ready) begin
                n_pop++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL pop_unexpected got_pc=%h want=none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (out_pc !== e || out_inst !== e[31:0]) begin
                        bad++; $display("FAIL pop_order got_pc=%h inst=%h want_pc=%h", out_pc, out_inst, e);
                    end
                end
            end
            if (imem_req) begin
                n_req++;
                total++; if (imem_addr !== model_pc) begin bad++; $display("FAIL req_addr got=%h want=%h", imem_addr, model_pc); end
                exp_q.push_back(model_pc);
                model_pc  = model_pc + 64'd4;
                next_data = imem_addr[31:0];
            end
        end
        @(posedge clk);
        #1 imem_rdata = next_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0; redirect = 1'b0;
        repeat (2) begin #1; tick(); end
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        int p0;
        p0 = n_pop;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k == 0) begin
                total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin bad++; $display("FAIL first_req got=%b/%h want=1/%h", imem_req, imem_addr, RESET_PC); end
            end
            total++; if (out_valid !== (k >= LAT)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", k, out_valid, (k >= LAT)); end
            tick();
        end
        total++; if (n_pop - p0 != 12 - LAT) begin bad++; $display("FAIL stream_pops got=%0d want=%0d", n_pop - p0, 12 - LAT); end
    endtask

    task automatic test_backpressure();
        int r0;
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h100;
        #1; tick();
        redirect = 1'b0;
        r0 = n_req;
        repeat (10) begin #1; tick(); end
        #1;
        total++; if (n_req - r0 != 4) begin bad++; $display("FAIL bp_reqs got=%0d want=4", n_req - r0); end
        total++; if (count !== 3'(DEPTH)) begin bad++; $display("FAIL bp_count got=%0d want=%0d", count, DEPTH); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b want=0", imem_req); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_gap cyc=%0d got=%b want=1", k, out_valid); end
            tick();
        end
    endtask

    task automatic test_redirect();
        bit found;
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h200;
        #1; tick();
        redirect = 1'b0;
        repeat (4) begin #1; tick(); end
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL redir_setup_count got=%0d want=3", count); end
        redirect = 1'b1; redirect_pc = 64'h1003; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", out_valid); end
        tick();
        redirect = 1'b0;
        #1;
        total++; if (count !== '0) begin bad++; $display("FAIL redir_count got=%0d want=0", count); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin bad++; $display("FAIL redir_addr got=%b/%h want=1/1000", imem_req, imem_addr); end
        found = 1'b0;
        for (int k = 1; k <= 10 && !found; k++) begin
            if (k > 1) #1;
            if (out_valid) begin
                found = 1'b1;
                total++; if (k != LAT + 1) begin bad++; $display("FAIL redir_latency got=%0d want=%0d", k, LAT + 1); end
                total++; if (out_pc !== 64'h1000) begin bad++; $display("FAIL redir_first_pc got=%h want=1000", out_pc); end
            end
            tick();
        end
        if (!found) begin total++; bad++; $display("FAIL redir_timeout got=no_valid want=valid"); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFD;
        #1; tick();
        redirect = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%b/%h want=1/fffffffffffffffc", imem_req, imem_addr); end
        tick();
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/0", imem_req, imem_addr); end
        tick();
        repeat (4) begin #1; tick(); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        repeat (8) begin #1; tick(); end
        #1;
        total++; if (count !== 3'(DEPTH) || imem_req !== 1'b0) begin bad++; $display("FAIL full_setup got=%0d/%b want=%0d/0", count, imem_req, DEPTH); end
        reset = 1'b1;
        #1; tick();
        reset = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (count !== '0) begin bad++; $display("FAIL rfull_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rfull_valid got=%b want=0", out_valid); end
        total++; if (imem_addr !== RESET_PC || imem_req !== 1'b1) begin bad++; $display("FAIL rfull_addr got=%b/%h want=1/%h", imem_req, imem_addr, RESET_PC); end
        tick();
        #1;
        total++; if (out_valid !== (LAT == 1) || count !== '0) begin bad++; $display("FAIL empty_resp got=%b/%0d want=%b/0", out_valid, count, (LAT == 1)); end
        tick();
        repeat (4) begin #1; tick(); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF; model_pc = RESET_PC;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
